// File: rtl/mem_stage_lsu.sv
// RV64I MEM-stage load/store unit: one req/gnt/rvalid data-memory transaction per op,
// with load extension, store lane steering, misalignment/illegal checks and a bus timeout.
module mem_stage_lsu #(
    parameter int XLEN        = 64,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            op_valid_M,
    input  logic            op_we_M,
    input  logic [2:0]      funct3_M,
    input  logic [XLEN-1:0] addr_M,
    input  logic [XLEN-1:0] wdata_M,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [7:0]      dmem_wstrb,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [XLEN-1:0] ld_data_M,
    output logic            stall_M,
    output logic            fault_M
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST_CNT = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;

    state_t          r_state;
    state_t          w_next;
    logic [XLEN-1:0] r_addr;
    logic [2:0]      r_off;
    logic [2:0]      r_funct3;
    logic            r_we;
    logic [7:0]      r_wstrb;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_ld_data;
    logic [CW-1:0]   r_cnt;
    logic            r_tofault;

    logic            w_misaligned;
    logic            w_illegal;
    logic            w_bad;
    logic            w_accept;
    logic [7:0]      w_strb;
    logic [XLEN-1:0] w_lane;
    logic [XLEN-1:0] w_ext;
    logic            w_timeout;
    logic            w_to_fire;

    always_comb begin
        w_misaligned = 1'b0;
        case (funct3_M[1:0])
            2'd1:    w_misaligned = addr_M[0];
            2'd2:    w_misaligned = |addr_M[1:0];
            2'd3:    w_misaligned = |addr_M[2:0];
            default: w_misaligned = 1'b0;
        endcase
        w_illegal = op_we_M ? funct3_M[2] : (funct3_M == 3'd7);
        w_bad     = w_misaligned | w_illegal;
        w_accept  = (r_state == S_IDLE) && op_valid_M && !w_bad;

        w_strb = 8'h00;
        case (funct3_M[1:0])
            2'd0:    w_strb = 8'h01 << addr_M[2:0];
            2'd1:    w_strb = 8'h03 << addr_M[2:0];
            2'd2:    w_strb = 8'h0F << addr_M[2:0];
            default: w_strb = 8'hFF;
        endcase

        w_lane = dmem_rdata >> {r_off, 3'b000};
        w_ext  = w_lane;
        case (r_funct3)
            3'd0:    w_ext = {{56{w_lane[7]}},  w_lane[7:0]};
            3'd1:    w_ext = {{48{w_lane[15]}}, w_lane[15:0]};
            3'd2:    w_ext = {{32{w_lane[31]}}, w_lane[31:0]};
            3'd4:    w_ext = {56'd0, w_lane[7:0]};
            3'd5:    w_ext = {48'd0, w_lane[15:0]};
            3'd6:    w_ext = {32'd0, w_lane[31:0]};
            default: w_ext = w_lane;
        endcase

        // A completing gnt/rvalid on the last allowed cycle wins over the timeout.
        w_timeout = (TIMEOUT_CYC != 0) && (r_cnt == LAST_CNT);
        w_to_fire = w_timeout && (((r_state == S_REQ)  && !dmem_gnt) ||
                                  ((r_state == S_RESP) && !dmem_rvalid));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_REQ;
            S_REQ: begin
                if (dmem_gnt)       w_next = r_we ? S_DONE : S_RESP;
                else if (w_to_fire) w_next = S_DONE;
            end
            S_RESP: if (dmem_rvalid || w_to_fire) w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_addr    <= '0;
            r_off     <= '0;
            r_funct3  <= '0;
            r_we      <= 1'b0;
            r_wstrb   <= '0;
            r_wdata   <= '0;
            r_ld_data <= '0;
            r_cnt     <= '0;
            r_tofault <= 1'b0;
        end else begin
            r_tofault <= w_to_fire;
            if (w_accept) begin
                r_addr   <= {addr_M[XLEN-1:3], 3'b000};
                r_off    <= addr_M[2:0];
                r_funct3 <= funct3_M;
                r_we     <= op_we_M;
                r_wstrb  <= op_we_M ? w_strb : 8'h00;
                r_wdata  <= wdata_M << {addr_M[2:0], 3'b000};
                r_cnt    <= '0;
            end else if ((r_state == S_REQ) || (r_state == S_RESP)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if ((r_state == S_RESP) && dmem_rvalid) begin
                r_ld_data <= w_ext;
            end
        end
    end

    always_comb begin
        dmem_req   = (r_state == S_REQ);
        dmem_we    = (r_state == S_REQ) && r_we;
        dmem_wstrb = (r_state == S_REQ) ? r_wstrb : 8'h00;
        dmem_addr  = r_addr;
        dmem_wdata = r_wdata;
        ld_data_M  = r_ld_data;
        stall_M    = w_accept || (r_state == S_REQ) || (r_state == S_RESP);
        fault_M    = ((r_state == S_IDLE) && op_valid_M && w_bad) ||
                     ((r_state == S_DONE) && r_tofault);
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed vectors plus randomized accesses
// compared against an arithmetic reference model of loads, stores and faults.
module tb_mem_stage_lsu;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid_M;
    logic        op_we_M;
    logic [2:0]  funct3_M;
    logic [63:0] addr_M;
    logic [63:0] wdata_M;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [7:0]  dmem_wstrb;
    logic [63:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [63:0] dmem_rdata;
    logic [63:0] ld_data_M;
    logic        stall_M;
    logic        fault_M;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] lastLd = 64'd0;

    mem_stage_lsu #(.XLEN(64), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .op_valid_M(op_valid_M), .op_we_M(op_we_M), .funct3_M(funct3_M),
        .addr_M(addr_M), .wdata_M(wdata_M),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .ld_data_M(ld_data_M), .stall_M(stall_M), .fault_M(fault_M)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int sizeOf(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    // Reference load: slice the addressed bytes, then reinterpret as signed or unsigned.
    function automatic logic [63:0] modelLoad(input logic [2:0] f3, input logic [2:0] off,
                                              input logic [63:0] rd);
        logic [63:0] lane;
        logic [63:0] span;
        logic [63:0] v;
        lane = rd >> (8 * off);
        if (sizeOf(f3) == 8) return lane;
        span = 64'd1 << (8 * sizeOf(f3));
        v = lane % span;
        if (f3 < 3'd4 && v >= span / 2) v = v - span;
        return v;
    endfunction

    function automatic logic [7:0] modelStrb(input logic [2:0] f3, input logic [2:0] off);
        int mask;
        mask = ((1 << sizeOf(f3)) - 1) << off;
        return mask[7:0];
    endfunction

    function automatic logic modelBad(input logic we, input logic [2:0] f3, input logic [63:0] a);
        logic illegal;
        illegal = we ? (f3 >= 3'd4) : (f3 == 3'd7);
        return illegal || ((a % 64'(sizeOf(f3))) != 64'd0);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic we, input logic [2:0] f3,
                                 input logic [63:0] a, input logic [63:0] wd);
        op_valid_M = v;
        op_we_M    = we;
        funct3_M   = f3;
        addr_M     = a;
        wdata_M    = wd;
    endtask

    task automatic junkStimulus();
        applyStimulus(1'b1, 1'($urandom), 3'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
    endtask

    task automatic runAccess(input logic we, input logic [2:0] f3, input logic [63:0] a,
                             input logic [63:0] wd, input logic [63:0] rd,
                             input int gdelay, input int rdelay);
        logic [63:0] expAddr;
        expAddr = a & ~64'd7;
        @(posedge clk); #1;
        applyStimulus(1'b1, we, f3, a, wd);
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        @(negedge clk);
        checkOutput("idle ld hold", ld_data_M, lastLd);
        checkOutput("accept stall", 64'(stall_M), 64'd1);
        checkOutput("accept fault", 64'(fault_M), 64'd0);
        checkOutput("accept req", 64'(dmem_req), 64'd0);
        for (int i = 0; i <= gdelay; i++) begin
            @(posedge clk); #1;
            junkStimulus();
            dmem_gnt = (i == gdelay);
            @(negedge clk);
            checkOutput("req req", 64'(dmem_req), 64'd1);
            checkOutput("req addr", dmem_addr, expAddr);
            checkOutput("req we", 64'(dmem_we), 64'(we));
            checkOutput("req strb", 64'(dmem_wstrb), we ? 64'(modelStrb(f3, a[2:0])) : 64'd0);
            if (we) checkOutput("req wdata", dmem_wdata, wd << (8 * a[2:0]));
            checkOutput("req stall", 64'(stall_M), 64'd1);
            checkOutput("req fault", 64'(fault_M), 64'd0);
        end
        if (!we) begin
            for (int j = 1; j <= rdelay; j++) begin
                @(posedge clk); #1;
                dmem_gnt    = 1'b0;
                dmem_rvalid = (j == rdelay);
                dmem_rdata  = (j == rdelay) ? rd : {$urandom, $urandom};
                @(negedge clk);
                checkOutput("resp req", 64'(dmem_req), 64'd0);
                checkOutput("resp stall", 64'(stall_M), 64'd1);
            end
            lastLd = modelLoad(f3, a[2:0], rd);
        end
        @(posedge clk); #1;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        dmem_rdata = {$urandom, $urandom};
        op_valid_M = 1'b0;
        @(negedge clk);
        checkOutput("done stall", 64'(stall_M), 64'd0);
        checkOutput("done fault", 64'(fault_M), 64'd0);
        checkOutput("done req", 64'(dmem_req), 64'd0);
        checkOutput("done ld data", ld_data_M, lastLd);
        @(posedge clk);
    endtask

    task automatic runBad(input logic we, input logic [2:0] f3, input logic [63:0] a);
        @(posedge clk); #1;
        applyStimulus(1'b1, we, f3, a, {$urandom, $urandom});
        @(negedge clk);
        checkOutput("bad fault", 64'(fault_M), 64'(modelBad(we, f3, a)));
        checkOutput("bad stall", 64'(stall_M), 64'd0);
        checkOutput("bad req", 64'(dmem_req), 64'd0);
        @(posedge clk); #1;
        op_valid_M = 1'b0;
        @(negedge clk);
        checkOutput("bad fault drop", 64'(fault_M), 64'd0);
        checkOutput("bad no req", 64'(dmem_req), 64'd0);
        checkOutput("bad ld hold", ld_data_M, lastLd);
    endtask

    // Bus never completes: TO cycles across REQ+RESP, then a faulting DONE cycle.
    task automatic runTimeout(input logic we, input logic [2:0] f3, input logic [63:0] a);
        @(posedge clk); #1;
        applyStimulus(1'b1, we, f3, a, {$urandom, $urandom});
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        for (int c = 0; c < TO; c++) begin
            @(posedge clk); #1;
            op_valid_M = 1'b0;
            dmem_gnt = (!we && c == 0);
            @(negedge clk);
            checkOutput("to stall", 64'(stall_M), 64'd1);
            checkOutput("to fault early", 64'(fault_M), 64'd0);
        end
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        @(negedge clk);
        checkOutput("to fault", 64'(fault_M), 64'd1);
        checkOutput("to stall drop", 64'(stall_M), 64'd0);
        checkOutput("to req drop", 64'(dmem_req), 64'd0);
        checkOutput("to ld unchanged", ld_data_M, lastLd);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("to fault once", 64'(fault_M), 64'd0);
        checkOutput("to idle stall", 64'(stall_M), 64'd0);
    endtask

    task automatic runRandom(input int n);
        logic        we;
        logic [2:0]  f3;
        logic [63:0] a;
        for (int k = 0; k < n; k++) begin
            we = 1'($urandom);
            f3 = we ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
            a  = {$urandom, $urandom} & ~64'(sizeOf(f3) - 1);
            runAccess(we, f3, a, {$urandom, $urandom}, {$urandom, $urandom},
                      $urandom_range(0, 3), $urandom_range(1, 3));
        end
    endtask

    initial begin
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 64'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst req", 64'(dmem_req), 64'd0);
        checkOutput("rst we", 64'(dmem_we), 64'd0);
        checkOutput("rst strb", 64'(dmem_wstrb), 64'd0);
        checkOutput("rst addr", dmem_addr, 64'd0);
        checkOutput("rst wdata", dmem_wdata, 64'd0);
        checkOutput("rst ld", ld_data_M, 64'd0);
        checkOutput("rst stall", 64'(stall_M), 64'd0);
        checkOutput("rst fault", 64'(fault_M), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        runAccess(1'b0, 3'd0, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 0, 1);
        @(negedge clk);
        checkOutput("LB vector", ld_data_M, 64'hFFFF_FFFF_FFFF_FF80);
        runAccess(1'b0, 3'd6, 64'h2004, 64'd0, 64'hDEAD_BEEF_0000_0001, 0, 1);
        @(negedge clk);
        checkOutput("LWU vector", ld_data_M, 64'h0000_0000_DEAD_BEEF);
        runAccess(1'b0, 3'd2, 64'h2004, 64'd0, 64'hDEAD_BEEF_0000_0001, 1, 2);
        @(negedge clk);
        checkOutput("LW vector", ld_data_M, 64'hFFFF_FFFF_DEAD_BEEF);
        runAccess(1'b1, 3'd1, 64'h3006, 64'hABCD, 64'd0, 0, 1);
        runAccess(1'b1, 3'd3, 64'h5000, 64'h0123_4567_89AB_CDEF, 64'd0, 5, 1);
        runAccess(1'b0, 3'd3, 64'h6008, 64'd0, 64'h8765_4321_0FED_CBA9, 5, 1);
        runAccess(1'b0, 3'd5, 64'h7006, 64'd0, 64'hF00D_1234_5678_9ABC, 2, 3);

        runBad(1'b0, 3'd3, 64'h4004);
        runBad(1'b0, 3'd1, 64'h1001);
        runBad(1'b1, 3'd2, 64'h1002);
        runBad(1'b1, 3'd4, 64'h1000);
        runBad(1'b0, 3'd7, 64'h1000);

        runTimeout(1'b0, 3'd3, 64'h8000);
        runTimeout(1'b1, 3'd0, 64'h8001);

        runRandom(40);

        // Abandon a store mid-REQ with reset.
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b1, 3'd3, 64'h9008, 64'hFFFF_0000_FFFF_0000);
        @(posedge clk); #1;
        op_valid_M = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("pre-rst req", 64'(dmem_req), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("midrst req", 64'(dmem_req), 64'd0);
        checkOutput("midrst we", 64'(dmem_we), 64'd0);
        checkOutput("midrst strb", 64'(dmem_wstrb), 64'd0);
        checkOutput("midrst addr", dmem_addr, 64'd0);
        checkOutput("midrst wdata", dmem_wdata, 64'd0);
        checkOutput("midrst ld", ld_data_M, 64'd0);
        checkOutput("midrst stall", 64'(stall_M), 64'd0);
        checkOutput("midrst fault", 64'(fault_M), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        lastLd = 64'd0;

        runRandom(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
